datamem_sys: RTL and testbench

- Parametrised successor to the single-cycle data memory. Byte-addressed, little-endian storage in two regions: data and stack.
- Supports byte, halfword and word loads and stores, with sign/zero extension on loads.
- Replaces the zero-time syscall print loop with a clocked print engine. The engine streams characters over a valid/ready port and stalls the pipeline while busy.
- Sits in the MEM stage; `sys` arrives from the syscall decode.

---
 rtl/datamem_sys.sv | 140 ++++++++++++++
 tb/tb_datamem_sys.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_sys.sv
// datamem_sys: byte-addressed data/stack memory with a clocked syscall print engine
module datamem_sys #(
    parameter logic [31:0] DATA_BASE   = 32'h0040_0000,
    parameter int          DATA_WORDS  = 32768,
    parameter logic [31:0] STACK_BASE  = 32'hFFFF_0000,
    parameter int          STACK_WORDS = 16384,
    parameter int          MAX_STR     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    input  logic        sys,
    input  logic [31:0] regv,
    input  logic [31:0] rega,
    output logic        stall,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        sys_done,
    output logic        addr_err
);
    localparam int DW = $clog2(DATA_WORDS);
    localparam int SW = $clog2(STACK_WORDS);
    localparam int CW = $clog2(MAX_STR + 1);

    typedef enum logic [1:0] {IDLE, STR, NL, DONE} state_t;

    state_t        state;
    logic [31:0]   dmem [DATA_WORDS];
    logic [31:0]   smem [STACK_WORDS];
    logic [31:0]   ptr, ra, rword, rsh, rdat, wd;
    logic [CW-1:0] cnt;
    logic [3:0]    be;
    logic [1:0]    rsz;
    logic          armed, str, accept, take, rsg, r_err, w_err, pipe_err, stop, stop_err;

    function automatic logic in_data(input logic [31:0] a);
        return a >= DATA_BASE && a - DATA_BASE < 32'(4 * DATA_WORDS);
    endfunction

    function automatic logic in_stack(input logic [31:0] a);
        return a >= STACK_BASE && a - STACK_BASE < 32'(4 * STACK_WORDS);
    endfunction

    function automatic logic bad(input logic [31:0] a, input logic [1:0] sz);
        return !(in_data(a) || in_stack(a)) || sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    // the print engine owns the read port while walking a string
    assign str      = state == STR;
    assign ra       = str ? ptr : Addr;
    assign rsz      = str ? 2'b00 : MemSize;
    assign rsg      = !str && MemSigned;
    assign rword    = in_data(ra) ? dmem[DW'((ra - DATA_BASE) >> 2)] : smem[SW'((ra - STACK_BASE) >> 2)];
    assign rsh      = rword >> {ra[1:0], 3'b000};
    assign rdat     = rsz == 2'b00 ? {{24{rsg && rsh[7]}}, rsh[7:0]} : rsz == 2'b01 ? {{16{rsg && rsh[15]}}, rsh[15:0]} : rsh;
    assign r_err    = bad(ra, rsz);
    assign Rdata    = r_err ? '0 : rdat;
    assign w_err    = bad(Addr, MemSize);
    assign pipe_err = w_err && (MemWrite || !str);
    assign be       = MemSize == 2'b00 ? 4'b0001 << Addr[1:0] : MemSize == 2'b01 ? 4'b0011 << Addr[1:0] : 4'b1111;
    assign wd       = Wdata << {Addr[1:0], 3'b000};

    assign accept   = rst_n && state == IDLE && sys && armed;
    assign stall    = rst_n && (state != IDLE || accept);
    assign take     = !char_valid || char_ready;
    assign stop     = Rdata[7:0] == 8'h00 || cnt == CW'(MAX_STR);
    assign stop_err = r_err || (Rdata[7:0] != 8'h00 && cnt == CW'(MAX_STR));

    always_ff @(posedge clk)
        if (MemWrite && !w_err)
            for (int i = 0; i < 4; i++)
                if (be[i]) begin
                    if (in_data(Addr))
                        dmem[DW'((Addr - DATA_BASE) >> 2)][8*i +: 8] <= wd[8*i +: 8];
                    else
                        smem[SW'((Addr - STACK_BASE) >> 2)][8*i +: 8] <= wd[8*i +: 8];
                end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            armed      <= 1'b1;
            char_valid <= 1'b0;
            char_data  <= '0;
            sys_done   <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            sys_done <= 1'b0;
            armed    <= !sys || (armed && !accept);
            if (pipe_err)
                addr_err <= 1'b1;
            case (state)
                IDLE:
                    if (accept) begin
                        if (regv == 32'd4) begin
                            ptr   <= rega;
                            cnt   <= '0;
                            state <= STR;
                        end else if (regv == 32'd11) begin
                            char_valid <= 1'b1;
                            char_data  <= rega[7:0];
                            state      <= NL;
                        end else begin
                            sys_done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                STR:
                    if (take) begin
                        char_valid <= 1'b1;
                        if (stop) begin
                            char_data <= 8'h0A;
                            state     <= NL;
                            if (stop_err)
                                addr_err <= 1'b1;
                        end else begin
                            char_data <= Rdata[7:0];
                            ptr       <= ptr + 32'd1;
                            cnt       <= cnt + CW'(1);
                        end
                    end
                NL:
                    if (char_ready) begin
                        char_valid <= 1'b0;
                        sys_done   <= 1'b1;
                        state      <= DONE;
                    end
                default:
                    state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_datamem_sys.sv
// tb_datamem_sys: randomized self-checking bench against a byte-level memory and string model
module tb_datamem_sys;
    localparam logic [31:0] DB = 32'h0040_0000;
    localparam logic [31:0] SB = 32'hFFFF_0000;
    localparam int MAXS = 4;

    logic clk = 1'b0, rst_n = 1'b0, MemWrite = 1'b0, MemSigned = 1'b0, sys = 1'b0, char_ready = 1'b0;
    logic [1:0] MemSize = 2'b10;
    logic [31:0] Addr = DB, Wdata = '0, regv = '0, rega = '0;
    logic [31:0] Rdata;
    logic stall, char_valid, sys_done, addr_err;
    logic [7:0] char_data;

    int passed = 0, total = 0;
    logic [7:0] mem [logic [31:0]];
    logic [7:0] exp_q[$], got_q[$];
    int got_cyc[$];
    int done_cyc, done_cnt, hold_bad, stall_bad, rearm_bad;
    logic exp_err, timeout;

    always #5 clk = ~clk;

    datamem_sys #(.MAX_STR(MAXS)) dut (
        .clk(clk), .rst_n(rst_n), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
        .Addr(Addr), .Wdata(Wdata), .Rdata(Rdata), .sys(sys), .regv(regv), .rega(rega),
        .stall(stall), .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .sys_done(sys_done), .addr_err(addr_err)
    );

    function automatic logic in_rng(input logic [31:0] a);
        longint unsigned x = 64'(a);
        return (x >= 64'(DB) && x < 64'(DB) + 64'd131072) || (x >= 64'(SB) && x < 64'(SB) + 64'd65536);
    endfunction

    function automatic logic ok(input logic [31:0] a, input logic [1:0] sz);
        return in_rng(a) && (sz == 2'b00 || (sz == 2'b01 && a[0] == 1'b0) || (sz == 2'b10 && a[1:0] == 2'b00));
    endfunction

    function automatic logic [7:0] mb(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [7:0] b = mb(a);
        logic [15:0] h = {mb(a + 32'd1), b};
        if (!ok(a, sz)) return 32'h0;
        if (sz == 2'b00) return {{24{sg & b[7]}}, b};
        if (sz == 2'b01) return {{16{sg & h[15]}}, h};
        return {mb(a + 32'd3), mb(a + 32'd2), h};
    endfunction

    function automatic void model_str(input logic [31:0] a);
        logic [31:0] p = a;
        int n = 0;
        exp_q.delete();
        exp_err = 1'b0;
        while (1'b1) begin
            if (!in_rng(p)) begin exp_err = 1'b1; break; end
            if (mb(p) == 8'h00) break;
            if (n == MAXS) begin exp_err = 1'b1; break; end
            exp_q.push_back(mb(p));
            p++;
            n++;
        end
        exp_q.push_back(8'h0A);
    endfunction

    task automatic do_reset;
        sys = 1'b0; MemWrite = 1'b0; Addr = DB; MemSize = 2'b10; char_ready = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        Addr = a; MemSize = sz; Wdata = d; MemWrite = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0; Addr = DB; MemSize = 2'b10;
        if (ok(a, sz))
            for (int i = 0; i < (sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4); i++)
                mem[a + 32'(i)] = d[8*i +: 8];
    endtask

    // drives one syscall to completion and records what the sink saw
    task automatic run_print(input logic [31:0] v, input logic [31:0] a, input int mode);
        int cyc = 0;
        logic pv = 1'b0;
        logic [7:0] pd = 8'h00;
        got_q.delete(); got_cyc.delete();
        done_cyc = -1; done_cnt = 0; hold_bad = 0; stall_bad = 0; rearm_bad = 0;
        regv = v; rega = a; sys = 1'b1;
        while (done_cnt == 0 && cyc < 300) begin
            char_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(1));
            @(negedge clk);
            if (pv && (!char_valid || char_data !== pd)) hold_bad++;
            if (stall !== 1'b1) stall_bad++;
            if (char_valid && char_ready) begin got_q.push_back(char_data); got_cyc.push_back(cyc); end
            if (sys_done) begin done_cnt++; done_cyc = cyc; end
            pv = char_valid && !char_ready;
            pd = char_data;
            @(posedge clk); #1;
            cyc++;
        end
        timeout = done_cnt == 0;
        char_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (sys_done || char_valid || stall) rearm_bad++;
        end
        sys = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else passed++;
        total++; if (char_valid !== 1'b0) $display("FAIL reset_char_valid: got %b expected 0", char_valid); else passed++;
        total++; if (sys_done !== 1'b0) $display("FAIL reset_sys_done: got %b expected 0", sys_done); else passed++;
        total++; if (addr_err !== 1'b0) $display("FAIL reset_addr_err: got %b expected 0", addr_err); else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_string;
        store(DB, 2'b10, 32'h6463_6261);
        store(DB + 32'd4, 2'b10, 32'h0);
        model_str(DB);
        run_print(32'd4, DB, 0);
        total++; if (timeout) $display("FAIL str_timeout: no sys_done within budget"); else passed++;
        total++; if (got_q.size() != exp_q.size()) $display("FAIL str_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL str_char%0d: expected %h", i, exp_q[i]); else passed++;
        end
        total++; if (got_cyc.size() != 5 || got_cyc[4] - got_cyc[0] != 4) $display("FAIL str_consecutive: got %0d transfers, not back to back", got_cyc.size()); else passed++;
        total++; if (got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size() - 1] + 1) $display("FAIL str_done_cycle: got %0d", done_cyc); else passed++;
        total++; if (done_cnt != 1) $display("FAIL str_done_count: got %0d expected 1", done_cnt); else passed++;
        total++; if (stall_bad != 0) $display("FAIL str_stall: got %0d low cycles expected 0", stall_bad); else passed++;
        total++; if (rearm_bad != 0) $display("FAIL str_edge_armed: got %0d active cycles expected 0", rearm_bad); else passed++;
        total++; if (addr_err !== exp_err) $display("FAIL str_addr_err: got %b expected %b", addr_err, exp_err); else passed++;
    endtask

    task automatic test_byte_ext;
        store(DB + 32'd2, 2'b00, 32'h0000_0080);
        for (int k = 0; k < 3; k++) begin
            Addr = DB + (k == 2 ? 32'd0 : 32'd2); MemSize = k == 2 ? 2'b10 : 2'b00; MemSigned = k == 0;
            #1;
            total++;
            if (Rdata !== m_load(Addr, MemSize, MemSigned)) $display("FAIL ext%0d: got %h expected %h", k, Rdata, m_load(Addr, MemSize, MemSigned)); else passed++;
        end
        MemSigned = 1'b0; Addr = DB; MemSize = 2'b10;
        @(posedge clk); #1;
    endtask

    task automatic test_random_rw;
        logic [31:0] a;
        logic [1:0] sz;
        for (int i = 0; i < 16; i++) begin
            store(DB + 32'h100 + 32'(4 * i), 2'b10, $urandom);
            store(SB + 32'h40 + 32'(4 * i), 2'b10, $urandom);
        end
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(1) ? DB + 32'h100 : SB + 32'h40) + 32'($urandom_range(60));
            sz = 2'($urandom_range(3));
            if ($urandom_range(1)) store(a, sz, $urandom);
            else begin
                Addr = a; MemSize = sz; MemSigned = 1'($urandom_range(1));
                #1;
                total++;
                if (Rdata !== m_load(a, sz, MemSigned)) $display("FAIL rand_load %h sz%0d: got %h expected %h", a, sz, Rdata, m_load(a, sz, MemSigned)); else passed++;
                @(posedge clk); #1;
                Addr = DB; MemSize = 2'b10; MemSigned = 1'b0;
            end
        end
        do_reset;
    endtask

    task automatic test_errors;
        logic [31:0] ea [6] = '{32'h0000_0010, DB - 32'd4, DB + 32'h0001_FFFC, DB + 32'h0002_0000, SB - 32'd4, 32'hFFFF_FFFC};
        store(SB, 2'b10, 32'hA5A5_A5A5);
        total++; if (addr_err !== 1'b0) $display("FAIL err_clean: got %b expected 0", addr_err); else passed++;
        store(SB + 32'd3, 2'b01, 32'h0000_BEEF);
        total++; if (addr_err !== 1'b1) $display("FAIL err_mis_half: got %b expected 1", addr_err); else passed++;
        Addr = SB; #1;
        total++; if (Rdata !== m_load(SB, 2'b10, 1'b0)) $display("FAIL err_mem_kept: got %h expected %h", Rdata, m_load(SB, 2'b10, 1'b0)); else passed++;
        do_reset;
        total++; if (addr_err !== 1'b0) $display("FAIL err_reset_clear: got %b expected 0", addr_err); else passed++;
        Addr = DB; MemSize = 2'b11; #1;
        total++; if (Rdata !== 32'h0) $display("FAIL err_size11: got %h expected 0", Rdata); else passed++;
        @(posedge clk); #1;
        total++; if (addr_err !== 1'b1) $display("FAIL err_size11_flag: got %b expected 1", addr_err); else passed++;
        for (int k = 0; k < 6; k++) begin
            do_reset;
            if (ok(ea[k], 2'b10)) store(ea[k], 2'b10, 32'hC0DE_0000 + 32'(k));
            Addr = ea[k]; MemSize = 2'b10; #1;
            total++;
            if (Rdata !== m_load(ea[k], 2'b10, 1'b0)) $display("FAIL bound_load %h: got %h expected %h", ea[k], Rdata, m_load(ea[k], 2'b10, 1'b0)); else passed++;
            @(posedge clk); #1;
            total++;
            if (addr_err !== !ok(ea[k], 2'b10)) $display("FAIL bound_flag %h: got %b expected %b", ea[k], addr_err, !ok(ea[k], 2'b10)); else passed++;
        end
        do_reset;
    endtask

    task automatic test_backpressure;
        store(DB + 32'h20, 2'b10, 32'h5A59_5857);
        store(DB + 32'h24, 2'b10, 32'h0);
        for (int m = 1; m < 3; m++) begin
            model_str(DB + 32'h20);
            run_print(32'd4, DB + 32'h20, m);
            total++; if (got_q.size() != 5 || timeout) $display("FAIL bp%0d_len: got %0d expected 5", m, got_q.size()); else passed++;
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL bp%0d_char%0d: expected %h", m, i, exp_q[i]); else passed++;
            end
            total++; if (hold_bad != 0) $display("FAIL bp%0d_hold: got %0d unstable cycles expected 0", m, hold_bad); else passed++;
            total++; if (done_cnt != 1) $display("FAIL bp%0d_done: got %0d expected 1", m, done_cnt); else passed++;
        end
    endtask

    task automatic test_max_str;
        do_reset;
        store(SB + 32'h100, 2'b10, 32'h3433_3231);
        store(SB + 32'h104, 2'b10, 32'h3837_3635);
        model_str(SB + 32'h100);
        run_print(32'd4, SB + 32'h100, 0);
        total++; if (got_q.size() != exp_q.size()) $display("FAIL max_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL max_char%0d: expected %h", i, exp_q[i]); else passed++;
        end
        total++; if (addr_err !== exp_err) $display("FAIL max_addr_err: got %b expected %b", addr_err, exp_err); else passed++;
        total++; if (done_cnt != 1) $display("FAIL max_done: got %0d expected 1", done_cnt); else passed++;
    endtask

    task automatic test_reset_mid;
        int n = 0, cyc = 0, bad = 0;
        do_reset;
        regv = 32'd4; rega = DB; sys = 1'b1; char_ready = 1'b1;
        while (n < 2 && cyc < 50) begin
            @(negedge clk);
            if (char_valid && char_ready) n++;
            if (n < 2) begin @(posedge clk); #1; end
            cyc++;
        end
        total++; if (n != 2) $display("FAIL mid_progress: got %0d chars expected 2", n); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (char_valid !== 1'b0) $display("FAIL mid_char_valid: got %b expected 0", char_valid); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL mid_stall: got %b expected 0", stall); else passed++;
        sys = 1'b0; char_ready = 1'b0;
        repeat (3) begin @(negedge clk); if (sys_done) bad++; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (sys_done) bad++; end
        total++; if (bad != 0) $display("FAIL mid_no_done: got %0d pulses expected 0", bad); else passed++;
        @(posedge clk); #1;
        model_str(DB);
        run_print(32'd4, DB, 0);
        total++; if (got_q.size() != exp_q.size()) $display("FAIL mid_restart_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL mid_restart_char%0d: expected %h", i, exp_q[i]); else passed++;
        end
    endtask

    task automatic test_services;
        logic [7:0] c = 8'($urandom_range(33, 126));
        run_print(32'd11, {24'h0, c}, 2);
        total++; if (got_q.size() != 1 || got_q[0] !== c) $display("FAIL putchar: got %0d chars expected one %h", got_q.size(), c); else passed++;
        total++; if (done_cnt != 1) $display("FAIL putchar_done: got %0d expected 1", done_cnt); else passed++;
        run_print(32'd10, 32'h0, 0);
        total++; if (got_q.size() != 0 || done_cnt != 1) $display("FAIL other_service: got %0d chars %0d done expected 0 and 1", got_q.size(), done_cnt); else passed++;
        do_reset;
        model_str(32'h10);
        run_print(32'd4, 32'h10, 0);
        total++; if (got_q.size() != 1 || got_q[0] !== 8'h0A) $display("FAIL oor_ptr: got %0d chars expected only 0a", got_q.size()); else passed++;
        total++; if (addr_err !== exp_err) $display("FAIL oor_ptr_err: got %b expected %b", addr_err, exp_err); else passed++;
    endtask

    initial begin
        test_reset;
        test_string;
        test_byte_ext;
        test_random_rw;
        test_errors;
        test_backpressure;
        test_max_str;
        test_reset_mid;
        test_services;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
